// File: rtl/regfile_lookup_arbiter_pkg.sv
// Shared scheduler types for the regfile lookup arbiter.
//   ROB_IDX_W    : ROB index width, also the tag width returned for an unresolved operand
//   REG_IDX_W    : architectural register index width
//   DATA_W       : operand data width
//   MAX_ID_W     : widest requester ID supported (NUM_REQ up to 8)
//   state_t      : response-holding FSM states
//   lookup_req_t : one requester's lookup fields
//   lookup_rsp_t : captured lookup response
package regfile_lookup_arbiter_pkg;
   localparam int ROB_IDX_W = 5;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;
   localparam int MAX_ID_W  = 3;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic [REG_IDX_W-1:0] idx_1;
      logic [REG_IDX_W-1:0] idx_2;
      logic                 need_1;
      logic                 need_2;
   } lookup_req_t;

   typedef struct packed {
      logic [MAX_ID_W-1:0] id;
      logic                valid_1;
      logic [DATA_W-1:0]   val_1;
      logic                valid_2;
      logic [DATA_W-1:0]   val_2;
   } lookup_rsp_t;
endpackage

// File: rtl/regfile_lookup_arbiter_if.sv
// Requester-side bus of the regfile lookup arbiter: per-requester lookup
// requests with a one-hot grant, and a single shared response channel.
//   master : issue-queue side (drives requests, rsp_ready)
//   slave  : arbiter side (drives req_ready and the response)
interface regfile_lookup_arbiter_if
   import regfile_lookup_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int REQ_ID_W = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0][REG_IDX_W-1:0]  req_idx_1;
   logic [NUM_REQ-1:0][REG_IDX_W-1:0]  req_idx_2;
   logic [NUM_REQ-1:0]                 req_need_1;
   logic [NUM_REQ-1:0]                 req_need_2;
   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [REQ_ID_W-1:0]                rsp_id;
   logic                               rsp_valid_1;
   logic                               rsp_valid_2;
   logic [DATA_W-1:0]                  rsp_val_1;
   logic [DATA_W-1:0]                  rsp_val_2;

   modport master (
      output req_valid, req_idx_1, req_idx_2, req_need_1, req_need_2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_valid_1, rsp_valid_2, rsp_val_1, rsp_val_2
   );

   modport slave (
      input  req_valid, req_idx_1, req_idx_2, req_need_1, req_need_2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_valid_1, rsp_valid_2, rsp_val_1, rsp_val_2
   );
endinterface

// File: rtl/regfile_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index this cycle
//   grant  : one-hot grant (zero when no request)
//   winner : encoded index of the granted request
//   any    : at least one request is valid
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    winner,
   output logic               any
);
   always_comb begin
      int idx;
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      // Scan ptr, ptr+1, ... modulo NUM_REQ; first valid request wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            winner     = ID_W'(idx);
         end
      end
   end
endmodule

// File: rtl/regfile_lookup_arbiter.sv
// Shares the regfile's two-source lookup port among NUM_REQ issue queues.
// Grants round-robin, captures the regfile's combinational reply into a
// one-entry response register, wakes tag-only operands from the commit bus
// while the response waits, and drops the response on flush.
//   clk, rst          : clock, asynchronous active-low reset
//   flush_all         : ROB flush
//   bus               : requester requests / one-hot grant / response channel
//   rf_lookup_x/idx_x : regfile lookup drive (combinational in grant cycle)
//   rf_valid_x/val_x  : regfile reply (value, or ROB tag when invalid)
//   cm_*              : commit bus
module regfile_lookup_arbiter
   import regfile_lookup_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_all,
   regfile_lookup_arbiter_if.slave bus,
   output logic                  rf_lookup_1,
   output logic                  rf_lookup_2,
   output logic [REG_IDX_W-1:0]  rf_idx_1,
   output logic [REG_IDX_W-1:0]  rf_idx_2,
   input  logic                  rf_valid_1,
   input  logic                  rf_valid_2,
   input  logic [DATA_W-1:0]     rf_val_1,
   input  logic [DATA_W-1:0]     rf_val_2,
   input  logic                  cm_valid,
   input  logic [ROB_IDX_W-1:0]  cm_rob_idx,
   input  logic [REG_IDX_W-1:0]  cm_reg_idx,
   input  logic [DATA_W-1:0]     cm_value
);
   lookup_req_t          reqs [NUM_REQ];
   lookup_req_t          sel;
   state_t               state_reg;
   logic [REQ_ID_W-1:0]  rr_ptr_reg;
   logic [REQ_ID_W-1:0]  rr_ptr_next;
   lookup_rsp_t          rsp_reg;
   logic [REG_IDX_W-1:0] src_idx_1_reg;
   logic [REG_IDX_W-1:0] src_idx_2_reg;
   logic [NUM_REQ-1:0]   grant_vec;
   logic [REQ_ID_W-1:0]  winner;
   logic                 any_req;
   logic                 can_grant;
   logic                 grant;
   logic                 wake_1;
   logic                 wake_2;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign reqs[gi] = '{idx_1:  bus.req_idx_1[gi],
                             idx_2:  bus.req_idx_2[gi],
                             need_1: bus.req_need_1[gi],
                             need_2: bus.req_need_2[gi]};
      end
   endgenerate

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (REQ_ID_W)
   ) u_rr_arbiter (
      .req    (bus.req_valid),
      .ptr    (rr_ptr_reg),
      .grant  (grant_vec),
      .winner (winner),
      .any    (any_req)
   );

   // rst gates the grant so nothing is offered to requesters while reset is held.
   assign can_grant = rst & ~flush_all & ((state_reg == IDLE) | bus.rsp_ready);
   assign grant     = can_grant & any_req;
   assign sel       = reqs[winner];

   assign bus.req_ready = grant ? grant_vec : '0;
   assign rf_lookup_1   = grant & sel.need_1;
   assign rf_lookup_2   = grant & sel.need_2;
   assign rf_idx_1      = grant ? sel.idx_1 : '0;
   assign rf_idx_2      = grant ? sel.idx_2 : '0;

   assign rr_ptr_next = (winner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

   // A held tag matches a commit only if both the ROB slot and the register agree.
   assign wake_1 = ~rsp_reg.valid_1 & cm_valid &
                   (cm_rob_idx == rsp_reg.val_1[ROB_IDX_W-1:0]) & (cm_reg_idx == src_idx_1_reg);
   assign wake_2 = ~rsp_reg.valid_2 & cm_valid &
                   (cm_rob_idx == rsp_reg.val_2[ROB_IDX_W-1:0]) & (cm_reg_idx == src_idx_2_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         rsp_reg       <= '0;
         src_idx_1_reg <= '0;
         src_idx_2_reg <= '0;
      end else if (flush_all) begin
         state_reg <= IDLE;
         rsp_reg   <= '0;
      end else if (grant) begin
         // Also covers back-to-back: the old response retires on this edge.
         state_reg       <= HOLD;
         rr_ptr_reg      <= rr_ptr_next;
         rsp_reg.id      <= MAX_ID_W'(winner);
         rsp_reg.valid_1 <= sel.need_1 ? rf_valid_1 : 1'b1;
         rsp_reg.val_1   <= sel.need_1 ? rf_val_1 : '0;
         rsp_reg.valid_2 <= sel.need_2 ? rf_valid_2 : 1'b1;
         rsp_reg.val_2   <= sel.need_2 ? rf_val_2 : '0;
         src_idx_1_reg   <= sel.idx_1;
         src_idx_2_reg   <= sel.idx_2;
      end else if (state_reg == HOLD) begin
         if (bus.rsp_ready) begin
            state_reg <= IDLE;
            rsp_reg   <= '0;
         end else begin
            if (wake_1) begin
               rsp_reg.valid_1 <= 1'b1;
               rsp_reg.val_1   <= cm_value;
            end
            if (wake_2) begin
               rsp_reg.valid_2 <= 1'b1;
               rsp_reg.val_2   <= cm_value;
            end
         end
      end
   end

   assign bus.rsp_valid   = (state_reg == HOLD);
   assign bus.rsp_id      = rsp_reg.id[REQ_ID_W-1:0];
   assign bus.rsp_valid_1 = rsp_reg.valid_1;
   assign bus.rsp_valid_2 = rsp_reg.valid_2;
   assign bus.rsp_val_1   = rsp_reg.val_1;
   assign bus.rsp_val_2   = rsp_reg.val_2;
endmodule

// File: tb/tb_regfile_lookup_arbiter.sv
// Directed testbench for regfile_lookup_arbiter (NUM_REQ=3).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_regfile_lookup_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush_all;
   logic        rf_lookup_1, rf_lookup_2;
   logic [4:0]  rf_idx_1, rf_idx_2;
   logic        rf_valid_1, rf_valid_2;
   logic [31:0] rf_val_1, rf_val_2;
   logic        cm_valid;
   logic [4:0]  cm_rob_idx, cm_reg_idx;
   logic [31:0] cm_value;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_lookup_arbiter_if #(.NUM_REQ(3)) bus ();

   regfile_lookup_arbiter #(.NUM_REQ(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_all   (flush_all),
      .bus         (bus),
      .rf_lookup_1 (rf_lookup_1),
      .rf_lookup_2 (rf_lookup_2),
      .rf_idx_1    (rf_idx_1),
      .rf_idx_2    (rf_idx_2),
      .rf_valid_1  (rf_valid_1),
      .rf_valid_2  (rf_valid_2),
      .rf_val_1    (rf_val_1),
      .rf_val_2    (rf_val_2),
      .cm_valid    (cm_valid),
      .cm_rob_idx  (cm_rob_idx),
      .cm_reg_idx  (cm_reg_idx),
      .cm_value    (cm_value)
   );

   task automatic test_reset;
      rst = 1'b0;
      flush_all = 1'b0;
      rf_valid_1 = 1'b0; rf_valid_2 = 1'b0;
      rf_val_1 = '0; rf_val_2 = '0;
      cm_valid = 1'b0; cm_rob_idx = '0; cm_reg_idx = '0; cm_value = '0;
      bus.req_valid = 3'b111; bus.req_need_1 = 3'b111; bus.req_need_2 = 3'b000;
      bus.req_idx_1 = '0; bus.req_idx_2 = '0; bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
      checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
      checks++; if (bus.rsp_valid_1 !== 1'b0 || bus.rsp_valid_2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_x: got %b%b expected 00", bus.rsp_valid_1, bus.rsp_valid_2); end
      checks++; if (bus.rsp_val_1 !== 32'd0 || bus.rsp_val_2 !== 32'd0) begin errors++; $display("FAIL reset_rsp_val: got %h/%h expected 0/0", bus.rsp_val_1, bus.rsp_val_2); end
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", bus.req_ready); end
      checks++; if (rf_lookup_1 !== 1'b0) begin errors++; $display("FAIL reset_rf_lookup_1: got %b expected 0", rf_lookup_1); end
      $display("reset: req_ready=%b rsp_valid=%b", bus.req_ready, bus.rsp_valid);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 3'b000; bus.req_need_1 = 3'b000;
   endtask

   task automatic test_round_robin;
      int order [4] = '{0, 1, 2, 0};
      @(negedge clk);
      bus.req_valid = 3'b111; bus.req_need_1 = 3'b111;
      bus.req_idx_1[0] = 5'd1; bus.req_idx_1[1] = 5'd2; bus.req_idx_1[2] = 5'd3;
      rf_valid_1 = 1'b1; rf_val_1 = 32'h100; bus.rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (bus.req_ready !== (3'b001 << order[k])) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.req_ready, 3'b001 << order[k]); end
         checks++; if (rf_idx_1 !== 5'(order[k] + 1)) begin errors++; $display("FAIL rr_rf_idx_1[%0d]: got %0d expected %0d", k, rf_idx_1, order[k] + 1); end
         if (k > 0) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(order[k-1])) begin errors++; $display("FAIL rr_rsp_id[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", k, bus.rsp_valid, bus.rsp_id, order[k-1]); end
         end
         $display("round_robin: k=%0d req_ready=%b rsp_id=%0d", k, bus.req_ready, bus.rsp_id);
         @(negedge clk);
      end
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL rr_wrap_rsp_id: got %0d expected 0", bus.rsp_id); end
      @(negedge clk); #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_retire: got %b expected 0", bus.rsp_valid); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_single;
      @(negedge clk);
      bus.req_valid = 3'b001; bus.req_idx_1[0] = 5'd5;
      bus.req_need_1 = 3'b001; bus.req_need_2 = 3'b000;
      rf_valid_1 = 1'b1; rf_val_1 = 32'h1234; rf_valid_2 = 1'b0; rf_val_2 = 32'hBEEF;
      bus.rsp_ready = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL single_req_ready: got %b expected 001", bus.req_ready); end
      checks++; if (rf_lookup_1 !== 1'b1 || rf_idx_1 !== 5'd5) begin errors++; $display("FAIL single_lookup_1: got %b/%0d expected 1/5", rf_lookup_1, rf_idx_1); end
      checks++; if (rf_lookup_2 !== 1'b0) begin errors++; $display("FAIL single_lookup_2: got %b expected 0", rf_lookup_2); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got %b expected 0", bus.rsp_valid); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp: got valid=%b id=%0d expected 1/0", bus.rsp_valid, bus.rsp_id); end
      checks++; if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_val_1 !== 32'h1234) begin errors++; $display("FAIL single_src1: got %b/%h expected 1/00001234", bus.rsp_valid_1, bus.rsp_val_1); end
      checks++; if (bus.rsp_valid_2 !== 1'b1 || bus.rsp_val_2 !== 32'h0) begin errors++; $display("FAIL single_src2_unneeded: got %b/%h expected 1/00000000", bus.rsp_valid_2, bus.rsp_val_2); end
      $display("single: rsp_id=%0d val_1=%h val_2=%h", bus.rsp_id, bus.rsp_val_1, bus.rsp_val_2);
      // Pointer is now 1: with 0 and 1 both requesting, 1 must win (back-to-back).
      bus.req_valid = 3'b011; bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL single_ptr_grant: got %b expected 010", bus.req_ready); end
      checks++; if (rf_lookup_1 !== 1'b0 || rf_idx_1 !== 5'd2) begin errors++; $display("FAIL single_req1_lookup: got %b/%0d expected 0/2", rf_lookup_1, rf_idx_1); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin errors++; $display("FAIL b2b_rsp: got valid=%b id=%0d expected 1/1", bus.rsp_valid, bus.rsp_id); end
      checks++; if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_val_1 !== 32'h0) begin errors++; $display("FAIL b2b_unneeded: got %b/%h expected 1/00000000", bus.rsp_valid_1, bus.rsp_val_1); end
      $display("back_to_back: rsp_id=%0d", bus.rsp_id);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_retire: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_backpressure;
      // Pointer is 2 here.
      bus.req_valid = 3'b100; bus.req_need_1 = 3'b111; bus.req_need_2 = 3'b000;
      bus.req_idx_1[2] = 5'd3; rf_valid_1 = 1'b1; rf_val_1 = 32'hAAAA; bus.rsp_ready = 1'b0;
      #1;
      checks++; if (bus.req_ready !== 3'b100) begin errors++; $display("FAIL bp_first_grant: got %b expected 100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b010; rf_val_1 = 32'h5555;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 000", c, bus.req_ready); end
         checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_val_1 !== 32'hAAAA) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%0d/%h expected 1/2/0000aaaa", c, bus.rsp_valid, bus.rsp_id, bus.rsp_val_1); end
         $display("backpressure: cycle=%0d req_ready=%b rsp_val_1=%h", c, bus.req_ready, bus.rsp_val_1);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_grant: got %b expected 010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_val_1 !== 32'h5555) begin errors++; $display("FAIL bp_new_rsp: got %0d/%h expected 1/00005555", bus.rsp_id, bus.rsp_val_1); end
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_retire: got %b expected 0", bus.rsp_valid); end
   endtask

   task automatic test_wakeup;
      // Pointer is 2; requester 2 needs source 1 (reg 9), regfile returns tag 7.
      bus.req_valid = 3'b100; bus.req_need_1 = 3'b100; bus.req_need_2 = 3'b000;
      bus.req_idx_1[2] = 5'd9; rf_valid_1 = 1'b0; rf_val_1 = 32'd7; bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 3'b000; rf_val_1 = 32'h1111;
      #1;
      checks++; if (bus.rsp_valid_1 !== 1'b0 || bus.rsp_val_1 !== 32'd7) begin errors++; $display("FAIL wake_capture_tag: got %b/%h expected 0/00000007", bus.rsp_valid_1, bus.rsp_val_1); end
      cm_valid = 1'b1; cm_rob_idx = 5'd7; cm_reg_idx = 5'd10; cm_value = 32'hDEAD;
      @(negedge clk); #1;
      checks++; if (bus.rsp_valid_1 !== 1'b0 || bus.rsp_val_1 !== 32'd7) begin errors++; $display("FAIL wake_wrong_reg: got %b/%h expected 0/00000007", bus.rsp_valid_1, bus.rsp_val_1); end
      cm_reg_idx = 5'd9;
      @(negedge clk);
      cm_valid = 1'b0;
      #1;
      checks++; if (bus.rsp_valid_1 !== 1'b1 || bus.rsp_val_1 !== 32'hDEAD) begin errors++; $display("FAIL wake_match: got %b/%h expected 1/0000dead", bus.rsp_valid_1, bus.rsp_val_1); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin errors++; $display("FAIL wake_still_held: got %b/%0d expected 1/2", bus.rsp_valid, bus.rsp_id); end
      $display("wakeup: rsp_valid_1=%b rsp_val_1=%h", bus.rsp_valid_1, bus.rsp_val_1);
   endtask

   task automatic test_flush;
      // Held response from requester 2, pointer 0.
      flush_all = 1'b1; bus.req_valid = 3'b010; bus.rsp_ready = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL flush_req_ready: got %b expected 000", bus.req_ready); end
      @(negedge clk);
      flush_all = 1'b0; bus.req_valid = 3'b000; bus.rsp_ready = 1'b0;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid: got %b expected 0", bus.rsp_valid); end
      // Pointer must still be 0, so requester 0 beats requester 2.
      bus.req_valid = 3'b101; bus.req_need_1 = 3'b111; rf_valid_1 = 1'b1; rf_val_1 = 32'h2222;
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL flush_ptr_kept: got %b expected 001", bus.req_ready); end
      $display("flush: rsp_valid=%b next_grant=%b", bus.rsp_valid, bus.req_ready);
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_val_1 !== 32'h2222) begin errors++; $display("FAIL flush_regrant: got %b/%h expected 1/00002222", bus.rsp_valid, bus.rsp_val_1); end
   endtask

   task automatic test_async_reset;
      // Mid low phase, no clock edge pending for several ns.
      #2;
      rst = 1'b0; bus.req_valid = 3'b111;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_val_1 !== 32'd0) begin errors++; $display("FAIL async_reset_rsp: got %b/%h expected 0/00000000", bus.rsp_valid, bus.rsp_val_1); end
      checks++; if (bus.req_ready !== 3'b000) begin errors++; $display("FAIL async_reset_req_ready: got %b expected 000", bus.req_ready); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (bus.req_ready !== 3'b001) begin errors++; $display("FAIL async_reset_first_grant: got %b expected 001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 3'b000;
      #1;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin errors++; $display("FAIL async_reset_rsp_after: got %b/%0d expected 1/0", bus.rsp_valid, bus.rsp_id); end
      $display("async_reset: rsp_valid=%b rsp_id=%0d", bus.rsp_valid, bus.rsp_id);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_wakeup();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
